// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel PWM sharing one prescaler and counter, edge- or center-aligned,
// with duty/period/mode double-buffered and applied only at period boundaries.
module pwm_multichannel #(
   parameter int CHANNELS = 16,
   parameter int RES      = 8,
   parameter int PRE_W    = 8,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en_out,
   input  logic [CHANNELS-1:0] en_pwm,
   input  logic                duty_wr,
   input  logic [CH_W-1:0]     duty_ch,
   input  logic [RES-1:0]      duty_data,
   input  logic [RES-1:0]      period,
   input  logic [PRE_W-1:0]    prescale,
   input  logic                center_mode,
   output logic [CHANNELS-1:0] out,
   output logic                period_tick
);
   logic [PRE_W-1:0]             pre_cnt_q, pre_cnt_d;
   logic [RES-1:0]               cnt_q, cnt_d, period_act_q, period_act_d;
   logic                         dir_q, dir_d, mode_act_q, mode_act_d;
   logic [CHANNELS-1:0][RES-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
   logic [CHANNELS-1:0]          out_q, out_d;
   logic                         tick_q;
   logic                         tick, top, down, bnd;

   always_comb begin
      tick = pre_cnt_q >= prescale;
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      top = cnt_q == period_act_q;
      // center boundary is the step from 1 to 0, which also covers turning at a top of 1
      bnd = tick & (mode_act_q ? (period_act_q == '0) | ((cnt_q == RES'(1)) & (dir_q | top)) : top);
      down = mode_act_q & (dir_q | top);
      cnt_d = !tick ? cnt_q : bnd ? '0 : down ? cnt_q - RES'(1) : cnt_q + RES'(1);
      dir_d = !tick ? dir_q : bnd ? 1'b0 : down;
      period_act_d = bnd ? period : period_act_q;
      mode_act_d = bnd ? center_mode : mode_act_q;
      duty_act_d = bnd ? duty_sh_q : duty_act_q;
      for (int i = 0; i < CHANNELS; i++) begin
         duty_sh_d[i] = (duty_wr && duty_ch == CH_W'(i)) ? duty_data : duty_sh_q[i];
         out_d[i] = en_out[i] & (~en_pwm[i] | (cnt_q < duty_act_q[i]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_q    <= '0;
         cnt_q        <= '0;
         dir_q        <= 1'b0;
         period_act_q <= '0;
         mode_act_q   <= 1'b0;
         duty_sh_q    <= '0;
         duty_act_q   <= '0;
         out_q        <= '0;
         tick_q       <= 1'b0;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         period_act_q <= period_act_d;
         mode_act_q   <= mode_act_d;
         duty_sh_q    <= duty_sh_d;
         duty_act_q   <= duty_act_d;
         out_q        <= out_d;
         tick_q       <= bnd;
      end
   end

   assign out = out_q;
   assign period_tick = tick_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed scenario bench for pwm_multichannel with 3 channels so an
// out-of-range channel index is representable.
module tb_pwm_multichannel;
   localparam int CH = 3, RES = 8, PRE_W = 8, CH_W = 2;
   logic             clk = 1'b0;
   logic             rst;
   logic [CH-1:0]    en_out, en_pwm, out;
   logic             duty_wr;
   logic [CH_W-1:0]  duty_ch;
   logic [RES-1:0]   duty_data, period;
   logic [PRE_W-1:0] prescale;
   logic             center_mode, period_tick;
   int               tests = 0;
   int               fails = 0;

   always #5 clk = ~clk;

   pwm_multichannel #(.CHANNELS(CH), .RES(RES), .PRE_W(PRE_W), .CH_W(CH_W)) dut (
      .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm), .duty_wr(duty_wr),
      .duty_ch(duty_ch), .duty_data(duty_data), .period(period), .prescale(prescale),
      .center_mode(center_mode), .out(out), .period_tick(period_tick)
   );

   task automatic write_duty(input logic [CH_W-1:0] ch, input logic [RES-1:0] v);
      duty_ch = ch;
      duty_data = v;
      duty_wr = 1'b1;
      @(negedge clk);
      duty_wr = 1'b0;
   endtask

   task automatic next_boundary(input string tag);
      int n = 0;
      @(negedge clk);
      while (!period_tick && n < 500) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (period_tick !== 1'b1) begin
         fails++;
         $display("FAIL %s: period_tick timeout, got %b want 1", tag, period_tick);
      end
   endtask

   task automatic measure(input int n, output int hi0, output int hi1, output int hi2, output int gap);
      hi0 = 0; hi1 = 0; hi2 = 0; gap = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         hi0 += int'(out[0]);
         hi1 += int'(out[1]);
         hi2 += int'(out[2]);
         if (period_tick && gap == 0) gap = k;
      end
   endtask

   task automatic test_reset();
      int h0, h1, h2, g;
      rst = 1'b1;
      en_out = '1; en_pwm = '1; duty_wr = 1'b0; duty_ch = '0; duty_data = '0;
      period = 8'd9; prescale = 8'd0; center_mode = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (out !== 3'b000) begin fails++; $display("FAIL reset_out: got %b want 000", out); end
      tests++;
      if (period_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", period_tick); end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (period_tick !== 1'b1) begin fails++; $display("FAIL reset_first_boundary: got %b want 1", period_tick); end
      measure(10, h0, h1, h2, g);
      tests++;
      if (g != 10) begin fails++; $display("FAIL reset_period_reload: gap %0d want 10", g); end
      tests++;
      if (h0 != 0) begin fails++; $display("FAIL reset_duty_zero: high %0d want 0", h0); end
   endtask

   task automatic test_edge_duty();
      int h0, h1, h2, g;
      write_duty(2'd0, 8'd3);
      next_boundary("edge_sync");
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 3) begin fails++; $display("FAIL edge_high: got %0d want 3", h0); end
      tests++;
      if (g != 10) begin fails++; $display("FAIL edge_period: gap %0d want 10", g); end
   endtask

   task automatic test_double_buffer();
      int h0, h1, h2, g;
      h0 = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         h0 += int'(out[0]);
         if (k == 4) begin duty_ch = 2'd0; duty_data = 8'd7; duty_wr = 1'b1; end
         if (k == 5) duty_wr = 1'b0;
      end
      tests++;
      if (h0 != 3) begin fails++; $display("FAIL dbuf_current: got %0d want 3", h0); end
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 7) begin fails++; $display("FAIL dbuf_next: got %0d want 7", h0); end
      tests++;
      if (g != 10) begin fails++; $display("FAIL dbuf_period: gap %0d want 10", g); end
      h0 = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         h0 += int'(out[0]);
         if (k == 9) begin duty_ch = 2'd0; duty_data = 8'd5; duty_wr = 1'b1; end
         if (k == 10) duty_wr = 1'b0;
      end
      tests++;
      if (h0 != 7) begin fails++; $display("FAIL bnd_write_current: got %0d want 7", h0); end
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 7) begin fails++; $display("FAIL bnd_write_deferred: got %0d want 7", h0); end
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 5) begin fails++; $display("FAIL bnd_write_applied: got %0d want 5", h0); end
   endtask

   task automatic test_center();
      int h0, h1, h2, g;
      center_mode = 1'b1; period = 8'd4; prescale = 8'd1;
      write_duty(2'd0, 8'd2);
      write_duty(2'd1, 8'd4);
      next_boundary("center_sync");
      measure(16, h0, h1, h2, g);
      tests++;
      if (h0 != 6) begin fails++; $display("FAIL center_duty2: got %0d want 6", h0); end
      tests++;
      if (h1 != 14) begin fails++; $display("FAIL center_duty4: got %0d want 14", h1); end
      tests++;
      if (g != 16) begin fails++; $display("FAIL center_period: gap %0d want 16", g); end
   endtask

   task automatic test_extremes();
      int h0, h1, h2, g;
      center_mode = 1'b0; period = 8'd9; prescale = 8'd0;
      write_duty(2'd0, 8'd0);
      next_boundary("zero_sync");
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 0) begin fails++; $display("FAIL duty_zero: got %0d want 0", h0); end
      write_duty(2'd0, 8'd10);
      next_boundary("full_sync");
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 10) begin fails++; $display("FAIL duty_above_period: got %0d want 10", h0); end
      en_pwm = 3'b001;
      @(negedge clk);
      tests++;
      if (out[2:1] !== 2'b11) begin fails++; $display("FAIL en_pwm_off: got %b want 11", out[2:1]); end
      en_out = 3'b000;
      @(negedge clk);
      tests++;
      if (out !== 3'b000) begin fails++; $display("FAIL en_out_off: got %b want 000", out); end
      en_out = '1; en_pwm = '1;
      write_duty(2'd3, 8'd5);
      next_boundary("oob_sync");
      measure(10, h0, h1, h2, g);
      tests++;
      if (h0 != 10 || h1 != 4 || h2 != 0) begin
         fails++;
         $display("FAIL oob_write: got %0d/%0d/%0d want 10/4/0", h0, h1, h2);
      end
   endtask

   task automatic test_prescale();
      int ticks = 0;
      logic [7:0] pat;
      center_mode = 1'b0; period = 8'd0; prescale = 8'd1;
      next_boundary("pre_sync1");
      next_boundary("pre_sync2");
      prescale = 8'd200;
      repeat (100) begin
         @(negedge clk);
         ticks += int'(period_tick);
      end
      tests++;
      if (ticks != 0) begin fails++; $display("FAIL pre_slow: ticks %0d want 0", ticks); end
      prescale = 8'd3;
      @(negedge clk);
      tests++;
      if (period_tick !== 1'b1) begin fails++; $display("FAIL pre_drop_immediate: got %b want 1", period_tick); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         pat[k] = period_tick;
      end
      tests++;
      if (pat !== 8'b1000_1000) begin fails++; $display("FAIL pre_every4: got %b want 10001000", pat); end
   endtask

   task automatic test_reset_mid();
      int h0, h1, h2, g;
      center_mode = 1'b0; period = 8'd9; prescale = 8'd0;
      write_duty(2'd0, 8'd5);
      next_boundary("mid_sync");
      @(negedge clk);
      tests++;
      if (out[0] !== 1'b1) begin fails++; $display("FAIL mid_pre_high: got %b want 1", out[0]); end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (out !== 3'b000) begin fails++; $display("FAIL mid_async_out: got %b want 000", out); end
      tests++;
      if (period_tick !== 1'b0) begin fails++; $display("FAIL mid_async_tick: got %b want 0", period_tick); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (period_tick !== 1'b1) begin fails++; $display("FAIL mid_first_boundary: got %b want 1", period_tick); end
      measure(10, h0, h1, h2, g);
      tests++;
      if (g != 10 || h0 != 0) begin
         fails++;
         $display("FAIL mid_after_release: gap %0d high %0d want 10 0", g, h0);
      end
   endtask

   initial begin
      test_reset();
      test_edge_duty();
      test_double_buffer();
      test_center();
      test_extremes();
      test_prescale();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
